// File: rtl/writeback_arbiter_if.sv
// Bus between the functional units, the writeback arbiter and the register file / CDB / memory.
// master drives results in and consumes writebacks; slave is the arbiter.
interface writeback_arbiter_if #(
    parameter int unsigned TAG_W = 4
);
    logic [2:0]       fu_valid;
    logic [2:0]       fu_ready;
    logic [5:0]       fu0_dest;
    logic [5:0]       fu1_dest;
    logic [5:0]       fu2_dest;
    logic [31:0]      fu0_value;
    logic [31:0]      fu1_value;
    logic [31:0]      fu2_value;
    logic [TAG_W-1:0] fu0_tag;
    logic [TAG_W-1:0] fu1_tag;
    logic [TAG_W-1:0] fu2_tag;
    logic             fu2_is_store;
    logic [31:0]      fu2_store_data;
    logic             rf_we;
    logic [5:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             mem_we;
    logic [9:0]       mem_addr;
    logic [31:0]      mem_wdata;
    logic             store_fault;
    logic [1:0]       grant_id;

    modport master (
        output fu_valid, fu0_dest, fu1_dest, fu2_dest, fu0_value, fu1_value, fu2_value,
               fu0_tag, fu1_tag, fu2_tag, fu2_is_store, fu2_store_data,
        input  fu_ready, rf_we, rf_waddr, rf_wdata, cdb_valid, cdb_tag, cdb_value,
               mem_we, mem_addr, mem_wdata, store_fault, grant_id
    );

    modport slave (
        input  fu_valid, fu0_dest, fu1_dest, fu2_dest, fu0_value, fu1_value, fu2_value,
               fu0_tag, fu1_tag, fu2_tag, fu2_is_store, fu2_store_data,
        output fu_ready, rf_we, rf_waddr, rf_wdata, cdb_valid, cdb_tag, cdb_value,
               mem_we, mem_addr, mem_wdata, store_fault, grant_id
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: one FIFO per functional unit, round-robin onto a single registered
// writeback / CDB / store port.
module writeback_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    writeback_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [5:0]       dest;
        logic [31:0]      value;
        logic [TAG_W-1:0] tag;
        logic             is_store;
        logic [31:0]      store_data;
    } entry_t;

    entry_t mem_q [3][DEPTH];
    entry_t mem_d [3][DEPTH];
    ptr_t   wr_ptr_q [3];
    ptr_t   wr_ptr_d [3];
    ptr_t   rd_ptr_q [3];
    ptr_t   rd_ptr_d [3];
    cnt_t   cnt_q [3];
    cnt_t   cnt_d [3];
    logic [1:0] rr_q, rr_d;

    logic             rf_we_q, rf_we_d;
    logic [5:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]      cdb_value_q, cdb_value_d;
    logic             mem_we_q, mem_we_d;
    logic [9:0]       mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             store_fault_q, store_fault_d;
    logic [1:0]       grant_id_q, grant_id_d;

    entry_t     in_e [3];
    entry_t     head;
    logic [2:0] fu_ready;
    logic [2:0] push;
    logic [2:0] pop;
    logic       found;
    logic [1:0] win;
    int         cand;

    always_comb begin
        in_e[0] = '{dest: bus.fu0_dest, value: bus.fu0_value, tag: bus.fu0_tag,
                    is_store: 1'b0, store_data: 32'h0};
        in_e[1] = '{dest: bus.fu1_dest, value: bus.fu1_value, tag: bus.fu1_tag,
                    is_store: 1'b0, store_data: 32'h0};
        in_e[2] = '{dest: bus.fu2_dest, value: bus.fu2_value, tag: bus.fu2_tag,
                    is_store: bus.fu2_is_store, store_data: bus.fu2_store_data};
    end

    // Ready is from the registered count only, so a full FIFO refuses a push even while popping.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fu_ready[i] = (cnt_q[i] != cnt_t'(DEPTH));
        end
    end

    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        cand  = 0;
        for (int k = 0; k < 3; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= 3) cand = cand - 3;
            if (!found && (cnt_q[cand] != '0)) begin
                found = 1'b1;
                win   = 2'(cand);
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        push     = '0;
        pop      = '0;
        if (found) begin
            pop[win] = 1'b1;
            rr_d     = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
        for (int i = 0; i < 3; i++) begin
            push[i] = bus.fu_valid[i] && fu_ready[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_e[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + ptr_t'(1);
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(1);
            if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + cnt_t'(1);
            else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - cnt_t'(1);
        end
    end

    always_comb begin
        head          = mem_q[win][rd_ptr_q[win]];
        rf_we_d       = 1'b0;
        rf_waddr_d    = '0;
        rf_wdata_d    = '0;
        cdb_valid_d   = 1'b0;
        cdb_tag_d     = '0;
        cdb_value_d   = '0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        store_fault_d = 1'b0;
        grant_id_d    = 2'd3;
        if (found) begin
            grant_id_d  = win;
            cdb_valid_d = 1'b1;
            cdb_tag_d   = head.tag;
            cdb_value_d = head.value;
            if (head.is_store) begin
                // Data memory is 1K words; anything above faults instead of writing.
                if (head.value[31:10] == '0) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head.value[9:0];
                    mem_wdata_d = head.store_data;
                end else begin
                    store_fault_d = 1'b1;
                end
            end else begin
                rf_we_d    = (head.dest != 6'd0);
                rf_waddr_d = head.dest;
                rf_wdata_d = head.value;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_q          <= 2'd0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_tag_q     <= '0;
            cdb_value_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            store_fault_q <= 1'b0;
            grant_id_q    <= 2'd3;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_tag_q     <= cdb_tag_d;
            cdb_value_q   <= cdb_value_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            store_fault_q <= store_fault_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign bus.fu_ready    = fu_ready;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_tag     = cdb_tag_q;
    assign bus.cdb_value   = cdb_value_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.store_fault = store_fault_q;
    assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a queue-based
// model of the per-FU FIFOs and round-robin CDB.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.TAG_W(TAG_W)) bus ();

    writeback_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]       dest;
        logic [31:0]      value;
        logic [TAG_W-1:0] tag;
        logic             is_store;
        logic [31:0]      sdata;
    } ent_t;

    ent_t mq [3][$];
    int   rr;
    int   n_checks = 0;
    int   n_fail = 0;

    logic             e_valid, e_rf_we, e_mem_we, e_fault;
    logic [TAG_W-1:0] e_tag;
    logic [31:0]      e_value, e_wdata, e_mwdata;
    logic [5:0]       e_waddr;
    logic [9:0]       e_maddr;
    logic [1:0]       e_grant;

    function automatic ent_t in_ent(int i);
        ent_t e;
        e.is_store = 1'b0;
        e.sdata    = 32'h0;
        if (i == 0) begin
            e.dest = bus.fu0_dest; e.value = bus.fu0_value; e.tag = bus.fu0_tag;
        end else if (i == 1) begin
            e.dest = bus.fu1_dest; e.value = bus.fu1_value; e.tag = bus.fu1_tag;
        end else begin
            e.dest = bus.fu2_dest; e.value = bus.fu2_value; e.tag = bus.fu2_tag;
            e.is_store = bus.fu2_is_store; e.sdata = bus.fu2_store_data;
        end
        return e;
    endfunction

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic cycle();
        ent_t e;
        int   win;
        bit   rdy [3];
        e_valid = 0; e_rf_we = 0; e_mem_we = 0; e_fault = 0; e_grant = 2'd3;
        e_tag = '0; e_value = '0; e_wdata = '0; e_mwdata = '0; e_waddr = '0; e_maddr = '0;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            rr = 0;
        end else begin
            for (int i = 0; i < 3; i++) rdy[i] = (mq[i].size() < DEPTH);
            win = -1;
            for (int k = 0; k < 3; k++)
                if (win < 0 && mq[(rr + k) % 3].size() > 0) win = (rr + k) % 3;
            if (win >= 0) begin
                e = mq[win].pop_front();
                rr = (win + 1) % 3;
                e_grant = 2'(win); e_valid = 1; e_tag = e.tag; e_value = e.value;
                if (e.is_store) begin
                    if (e.value < 32'd1024) begin
                        e_mem_we = 1; e_maddr = e.value[9:0]; e_mwdata = e.sdata;
                    end else e_fault = 1;
                end else begin
                    e_rf_we = (e.dest != 0); e_waddr = e.dest; e_wdata = e.value;
                end
            end
            for (int i = 0; i < 3; i++)
                if (bus.fu_valid[i] && rdy[i]) mq[i].push_back(in_ent(i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.fu0_dest = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
        bus.fu1_dest = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
        bus.fu2_dest = 6'($urandom);
        bus.fu0_value = $urandom; bus.fu1_value = $urandom;
        bus.fu2_value = $urandom_range(0, 1) ? 32'($urandom_range(0, 1023)) : $urandom;
        bus.fu0_tag = TAG_W'($urandom); bus.fu1_tag = TAG_W'($urandom);
        bus.fu2_tag = TAG_W'($urandom);
        bus.fu2_is_store = 1'($urandom); bus.fu2_store_data = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 0; bus.fu_valid = 3'b111; rand_inputs();
        cycle(); cycle();
        rst_n = 1; bus.fu_valid = 3'b000;
        n_checks++; if (bus.fu_ready !== 3'b111) begin n_fail++;
            $display("FAIL reset_ready got %b want 111", bus.fu_ready); end
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_cdb_valid got %b want 0", bus.cdb_valid); end
        n_checks++; if (bus.grant_id !== 2'd3) begin n_fail++;
            $display("FAIL reset_grant got %0d want 3", bus.grant_id); end
        n_checks++; if (bus.rf_we !== 1'b0 || bus.mem_we !== 1'b0 || bus.store_fault !== 1'b0)
            begin n_fail++; $display("FAIL reset_enables got %b%b%b want 000",
                bus.rf_we, bus.mem_we, bus.store_fault); end
        cycle();
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_no_push got cdb_valid %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_single_fu0();
        bus.fu_valid = 3'b001; bus.fu0_dest = 6'd5; bus.fu0_value = 32'h10; bus.fu0_tag = 4'd3;
        cycle();
        bus.fu_valid = 3'b000;
        n_checks++; if (bus.cdb_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_no_bypass got cdb_valid %b want 0", bus.cdb_valid); end
        cycle();
        n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 6'd5 || bus.rf_wdata !== 32'd16)
            begin n_fail++; $display("FAIL single_rf got we=%b a=%0d d=%0d want 1 5 16",
                bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_checks++; if (bus.cdb_tag !== 4'd3 || bus.grant_id !== 2'd0 || bus.cdb_valid !== 1'b1)
            begin n_fail++; $display("FAIL single_cdb got tag=%0d g=%0d v=%b want 3 0 1",
                bus.cdb_tag, bus.grant_id, bus.cdb_valid); end
        cycle();
        n_checks++; if (bus.cdb_valid !== 1'b0 || bus.rf_we !== 1'b0 || bus.grant_id !== 2'd3)
            begin n_fail++; $display("FAIL single_idle got v=%b we=%b g=%0d want 0 0 3",
                bus.cdb_valid, bus.rf_we, bus.grant_id); end
    endtask

    task automatic test_round_robin();
        rst_n = 0; cycle(); rst_n = 1;
        rand_inputs(); bus.fu2_is_store = 0; bus.fu_valid = 3'b111;
        cycle();
        bus.fu_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++; if (bus.grant_id !== 2'(k)) begin n_fail++;
                $display("FAIL rr_seq step %0d got %0d want %0d", k, bus.grant_id, k); end
        end
        bus.fu_valid = 3'b111;
        cycle();
        bus.fu_valid = 3'b000;
        cycle();
        n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++;
            $display("FAIL rr_wrap got %0d want 0", bus.grant_id); end
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_fu1_backpressure();
        logic [TAG_W-1:0] acc [$];
        logic [TAG_W-1:0] got [$];
        bit dropped = 0;
        bit same;
        rst_n = 0; cycle(); rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            rand_inputs(); bus.fu1_tag = TAG_W'(c); bus.fu_valid = 3'b111;
            if (bus.fu_ready[1]) acc.push_back(bus.fu1_tag);
            else if (!dropped) begin
                dropped = 1;
                n_checks++; if (acc.size() != 2) begin n_fail++;
                    $display("FAIL bp_drop_after got %0d accepted want 2", acc.size()); end
            end
            cycle();
            if (bus.cdb_valid && bus.grant_id == 2'd1) got.push_back(bus.cdb_tag);
        end
        bus.fu_valid = 3'b000;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (bus.cdb_valid && bus.grant_id == 2'd1) got.push_back(bus.cdb_tag);
        end
        n_checks++; if (!dropped) begin n_fail++;
            $display("FAIL bp_ready_drop got never dropped want drop"); end
        same = (got.size() == acc.size());
        if (same) for (int i = 0; i < got.size(); i++) if (got[i] !== acc[i]) same = 0;
        n_checks++; if (!same) begin n_fail++;
            $display("FAIL bp_order got %0d results want %0d in order", got.size(), acc.size());
        end
    endtask

    task automatic test_stores();
        bus.fu_valid = 3'b100; bus.fu2_is_store = 1; bus.fu2_value = 32'h40;
        bus.fu2_store_data = 32'hDEAD_BEEF; bus.fu2_tag = 4'd7; bus.fu2_dest = 6'd9;
        cycle(); bus.fu_valid = 3'b000; cycle();
        n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd64 ||
                        bus.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL store_mem got we=%b a=%0d d=%h want 1 64 deadbeef",
                bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.rf_we !== 1'b0 || bus.cdb_valid !== 1'b1 || bus.store_fault !== 1'b0)
            begin n_fail++; $display("FAIL store_ctl got rf_we=%b v=%b f=%b want 0 1 0",
                bus.rf_we, bus.cdb_valid, bus.store_fault); end
        bus.fu_valid = 3'b100; bus.fu2_value = 32'h400;
        cycle(); bus.fu_valid = 3'b000; cycle();
        n_checks++; if (bus.mem_we !== 1'b0 || bus.store_fault !== 1'b1 || bus.cdb_valid !== 1'b1
                        || bus.cdb_value !== 32'h400) begin n_fail++;
            $display("FAIL store_fault got we=%b f=%b v=%b val=%h want 0 1 1 400",
                bus.mem_we, bus.store_fault, bus.cdb_valid, bus.cdb_value); end
        cycle();
        n_checks++; if (bus.store_fault !== 1'b0) begin n_fail++;
            $display("FAIL fault_pulse got %b want 0", bus.store_fault); end
        bus.fu2_is_store = 0;
    endtask

    task automatic test_x0();
        bus.fu_valid = 3'b010; bus.fu1_dest = 6'd0; bus.fu1_value = 32'h1234; bus.fu1_tag = 4'd2;
        cycle(); bus.fu_valid = 3'b000; cycle();
        n_checks++; if (bus.rf_we !== 1'b0 || bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 4'd2)
            begin n_fail++; $display("FAIL x0 got rf_we=%b v=%b tag=%0d want 0 1 2",
                bus.rf_we, bus.cdb_valid, bus.cdb_tag); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        cycle();
        rand_inputs(); bus.fu2_is_store = 0; bus.fu_valid = 3'b101;
        cycle();
        rst_n = 0; bus.fu_valid = 3'b111;
        cycle();
        rst_n = 1; bus.fu_valid = 3'b000;
        n_checks++; if (bus.cdb_valid !== 1'b0 || bus.grant_id !== 2'd3) begin n_fail++;
            $display("FAIL midrst_clear got v=%b g=%0d want 0 3", bus.cdb_valid, bus.grant_id); end
        n_checks++; if (bus.fu_ready !== 3'b111) begin n_fail++;
            $display("FAIL midrst_ready got %b want 111", bus.fu_ready); end
        for (int c = 0; c < 4; c++) begin cycle(); if (bus.cdb_valid !== 1'b0) seen = 1; end
        n_checks++; if (seen) begin n_fail++;
            $display("FAIL midrst_discard got a buffered entry want none"); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            bus.fu_valid = 3'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
            n_checks++;
            if (bus.fu_ready !== {mq[2].size() != DEPTH, mq[1].size() != DEPTH,
                                  mq[0].size() != DEPTH}) begin n_fail++;
                $display("FAIL rnd_ready cyc %0d got %b", c, bus.fu_ready); end
            cycle();
            n_checks++; if (bus.grant_id !== e_grant || bus.cdb_valid !== e_valid) begin
                n_fail++; $display("FAIL rnd_grant cyc %0d got g=%0d v=%b want g=%0d v=%b",
                    c, bus.grant_id, bus.cdb_valid, e_grant, e_valid); end
            if (e_valid) begin
                n_checks++; if (bus.cdb_tag !== e_tag || bus.cdb_value !== e_value) begin
                    n_fail++; $display("FAIL rnd_cdb cyc %0d got %0d/%h want %0d/%h",
                        c, bus.cdb_tag, bus.cdb_value, e_tag, e_value); end
            end
            n_checks++; if (bus.rf_we !== e_rf_we || (e_rf_we && (bus.rf_waddr !== e_waddr ||
                            bus.rf_wdata !== e_wdata))) begin n_fail++;
                $display("FAIL rnd_rf cyc %0d got %b %0d %h want %b %0d %h", c, bus.rf_we,
                    bus.rf_waddr, bus.rf_wdata, e_rf_we, e_waddr, e_wdata); end
            n_checks++; if (bus.mem_we !== e_mem_we || bus.store_fault !== e_fault ||
                            (e_mem_we && (bus.mem_addr !== e_maddr ||
                            bus.mem_wdata !== e_mwdata))) begin n_fail++;
                $display("FAIL rnd_mem cyc %0d got %b %b %0d %h want %b %b %0d %h", c,
                    bus.mem_we, bus.store_fault, bus.mem_addr, bus.mem_wdata,
                    e_mem_we, e_fault, e_maddr, e_mwdata); end
        end
    endtask

    initial begin
        rst_n = 0;
        bus.fu_valid = 3'b000;
        rand_inputs();
        test_reset();
        test_single_fu0();
        test_round_robin();
        test_fu1_backpressure();
        test_stores();
        test_x0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Completion stage directly downstream of the issue/execute stage.
- Accepts results from the three functional units (FU0/FU1 ALU, FU2 load/store) and buffers each unit's results in its own FIFO.
- Arbitrates round-robin onto a single writeback/common-data bus (CDB): one register-file write, ROB completion broadcast, or memory store per cycle.
- Returns per-unit ready so the issue stage can mark functional units busy or free.

Parameters:
- DEPTH, 2, entries per FU FIFO (power of two, at least 2).
- TAG_W, 4, ROB tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fu_valid  in  3  bit i: FUi presents a result this cycle.
- fu_ready  out  3  bit i: FUi FIFO not full; a result is accepted when fu_valid[i] and fu_ready[i] are both high at the edge.
- fu0_dest, fu1_dest, fu2_dest  in  6 each  destination register index (0..63).
- fu0_value, fu1_value, fu2_value  in  32 each  result value; for a store this is the effective address.
- fu0_tag, fu1_tag, fu2_tag  in  TAG_W each  ROB tag.
- fu2_is_store  in  1  the FU2 result is a SW.
- fu2_store_data  in  32  store data (register rs2 value).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  6  register-file write address.
- rf_wdata  out  32  register-file write data.
- cdb_valid  out  1  completion broadcast valid.
- cdb_tag  out  TAG_W  completion broadcast tag.
- cdb_value  out  32  completion broadcast value.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  10  data-memory word address.
- mem_wdata  out  32  data-memory write data.
- store_fault  out  1  pulses when a store address is out of range.
- grant_id  out  2  FU index of the current CDB entry; 3 = none.

Behaviour:
- Reset, sampled at the edge while rst_n=0:
  - all FIFOs emptied, so fu_ready=3'b111 from the next cycle;
  - rr_ptr=0;
  - rf_we, cdb_valid, mem_we and store_fault =0;
  - rf_waddr, rf_wdata, cdb_tag, cdb_value, mem_addr, mem_wdata =0;
  - grant_id=3.
  - Reset mid-operation discards all buffered results and ignores fu_valid in that cycle.
- fu_ready[i] = (count_i != DEPTH).
  - It depends only on registered count, never on a same-cycle pop.
  - A full FIFO therefore refuses a push even while it is being popped.
- Push: at the edge, when fu_valid[i] and fu_ready[i], write {dest, value, tag, is_store, store_data} at wr_ptr_i. FU0 and FU1 store is_store=0.
- Pointers: wrap modulo DEPTH.
- Count update: push alone increments, pop alone decrements, push and pop together leave the count unchanged.
- Arbitration (combinational within the cycle):
  - Among non-empty FIFOs, pick the first in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The winner pops at the edge and rr_ptr becomes (winner+1) mod 3.
  - If no FIFO is non-empty, rr_ptr holds.
- Output register: the winning entry is loaded into the outputs at the same edge it pops. All outputs are registered and hold for exactly one cycle. In an idle cycle all enables return to 0 and grant_id=3.
  - ALU or load entry: cdb_valid=1, cdb_tag=tag, cdb_value=value, rf_waddr=dest, rf_wdata=value, rf_we=(dest!=0), mem_we=0.
  - x0 writes: suppressed on rf_we, but the CDB still broadcasts.
  - Store entry: rf_we=0, cdb_valid=1, cdb_value=address.
    - If value[31:10]==0: mem_we=1, mem_addr=value[9:0], mem_wdata=store_data.
    - Otherwise: mem_we=0, store_fault=1.
- Latency: a result accepted at edge E with no contention drives outputs after edge E+1.
  - A result cannot be pushed and popped at the same edge; there is no bypass.
- Throughput: one CDB entry per cycle in aggregate. Each FU sustains one result per cycle only when it is the sole requester.
- Ordering: strictly FIFO within each FU. No ordering guarantee across FUs; the ROB uses the tag.

Test Plan:
- Reset with fu_valid=3'b111 held -> no pushes; after reset release fu_ready=3'b111, cdb_valid=0, grant_id=3.
- Single push FU0 (dest=5, value=32'h10, tag=3) at edge E -> after E+1: rf_we=1, rf_waddr=5, rf_wdata=16, cdb_tag=3, grant_id=0; idle at E+2.
- All three FUs push once at the same edge with rr_ptr=0 -> grant_id sequence 0,1,2 over three consecutive cycles; then rr_ptr=0.
- FU1 pushes every cycle with DEPTH=2 while FU0 and FU2 are also busy -> fu_ready[1] drops after two accepted entries; no result lost or duplicated; per-FU tag order preserved.
- FU2 store (value=32'h0000_0040, store_data=32'hDEAD_BEEF) -> mem_we=1, mem_addr=64, mem_wdata=DEADBEEF, rf_we=0, cdb_valid=1.
- FU2 store with value=32'h0000_0400 -> mem_we=0, store_fault=1, cdb_valid=1.
- ALU result with dest=0 -> rf_we=0, cdb_valid=1.
- rst_n=0 with 2 entries buffered -> outputs cleared and buffered entries never appear.
